// File: rtl/tfab_pkg.sv
// -----------------------------------------------------------------------------
// tfab_pkg
// Shared types and constants for the PT-5 ternary fetch/hydration pipe.
//   trit_t         2-bit trit encoding used on every trit bus
//   TRIT_*         encodings for 0 / +1 / -1
//   PT5_MAX_BYTE   largest byte that is a valid 5-digit base-3 value (3^5-1)
//   pipe_state_t   frame sequencer states
//   digit_to_trit  maps a base-3 digit (0..2) to its trit encoding
// -----------------------------------------------------------------------------
package tfab_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b10;

  localparam logic [7:0] PT5_MAX_BYTE = 8'd242;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } pipe_state_t;

  function automatic trit_t digit_to_trit(input logic [1:0] i_digit);
    case (i_digit)
      2'd1:    return TRIT_POS;
      2'd2:    return TRIT_NEG;
      default: return TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/ternary_hydration_pipe_if.sv
// -----------------------------------------------------------------------------
// ternary_hydration_pipe_if
// Valid/ready beat stream from the hydration pipe to the vector engine.
//   out_valid    beat available (pipe -> engine)
//   out_ready    engine accepts beat (engine -> pipe)
//   out_w_trits  weight trits, lane L at [2L+:2]
//   out_i_trits  input trits, lane L at [2L+:2]
//   out_last     final beat of the frame
// master = pipe side, slave = engine side.
// -----------------------------------------------------------------------------
interface ternary_hydration_pipe_if #(
  parameter int LANES = 15
);

  logic               out_valid;
  logic               out_ready;
  logic [2*LANES-1:0] out_w_trits;
  logic [2*LANES-1:0] out_i_trits;
  logic               out_last;

  modport master (
    output out_valid,
    output out_w_trits,
    output out_i_trits,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_w_trits,
    input  out_i_trits,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pt5_unpacker.sv
// -----------------------------------------------------------------------------
// pt5_unpacker
// Combinational PT-5 decoder: one byte holds five base-3 digits, least
// significant digit first. Digit k drives lane k of the 5-lane output.
//   i_byte     packed byte
//   o_trits    5 trits, lane k at [2k+:2]; all zero when the byte is invalid
//   o_invalid  byte exceeds PT5_MAX_BYTE
// -----------------------------------------------------------------------------
module pt5_unpacker
  import tfab_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [9:0] o_trits,
  output logic       o_invalid
);

  logic [7:0] w_rem;
  logic [1:0] w_digit;

  // NOTE: every signal written here gets a value before any branch or loop,
  // so no latch can be inferred.
  // NOTE: blocking assignments are required: w_rem must carry from one digit
  // to the next within a single evaluation.
  always_comb begin
    o_invalid = (i_byte > PT5_MAX_BYTE);
    o_trits   = '0;
    w_rem     = i_byte;
    w_digit   = '0;
    for (int k = 0; k < 5; k++) begin
      w_digit          = 2'(w_rem % 8'd3);
      o_trits[2*k +: 2] = o_invalid ? TRIT_ZERO : digit_to_trit(w_digit);
      w_rem            = w_rem / 8'd3;
    end
  end

endmodule

// File: rtl/ternary_hydration_pipe.sv
// -----------------------------------------------------------------------------
// ternary_hydration_pipe
// Walks a weight bank and an input bank over a programmed frame (base, depth,
// stride), unpacks PT-5 bytes into lane-aligned trit vectors and streams them
// to the engine through a small output buffer with valid/ready backpressure.
//   clk, reset              clock; synchronous active-high reset
//   i_cfg_base_w/base_i     bank start addresses
//   i_cfg_depth             beats in frame (0 = empty frame, just pulses done)
//   i_cfg_stride            address increment per beat
//   i_cfg_bcast_i           hold input address at base_i for every beat
//   i_start                 frame start, cfg sampled with it; ignored while busy
//   o_busy, o_done          frame in progress / one-cycle end-of-frame pulse
//   o_err_invalid           sticky: a fetched byte was >242; cleared on start
//   o_mem_*_rd/addr         bank read strobes (always together) and addresses
//   i_mem_*_rdata           bank data, valid one cycle after the strobe
//   out_if                  beat stream (master side)
// Read issue is credit-limited: buffered + outstanding beats never exceed
// FIFO_DEPTH, so the buffer cannot overflow while the engine stalls.
// -----------------------------------------------------------------------------
module ternary_hydration_pipe
  import tfab_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int LANES       = 15,
  parameter int DEPTH_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_base_w,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_base_i,
  input  logic [DEPTH_WIDTH-1:0] i_cfg_depth,
  input  logic [7:0]             i_cfg_stride,
  input  logic                   i_cfg_bcast_i,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err_invalid,
  output logic                   o_mem_w_rd,
  output logic [ADDR_WIDTH-1:0]  o_mem_w_addr,
  input  logic [LANES/5*8-1:0]   i_mem_w_rdata,
  output logic                   o_mem_i_rd,
  output logic [ADDR_WIDTH-1:0]  o_mem_i_addr,
  input  logic [LANES/5*8-1:0]   i_mem_i_rdata,
  ternary_hydration_pipe_if.master out_if
);

  localparam int BYTES = LANES / 5;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2*LANES-1:0] w_trits;
    logic [2*LANES-1:0] i_trits;
    logic               last;
  } beat_t;

  // Frame configuration and sequencing
  pipe_state_t            r_state, w_state_next;
  logic [DEPTH_WIDTH-1:0] r_depth;
  logic [DEPTH_WIDTH-1:0] r_issue_cnt;
  logic [7:0]             r_stride;
  logic                   r_bcast;
  logic [ADDR_WIDTH-1:0]  r_addr_w, r_addr_i;

  // Read pipeline: r_rd = strobe this cycle, r_inflight = data arriving now
  logic r_rd, r_rd_last;
  logic r_inflight, r_inflight_last;
  logic r_done, r_err;

  // Output buffer
  beat_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic               w_start_ok, w_issue, w_last_issue, w_credit_ok;
  logic               w_pop, w_last_hs, w_done_set;
  beat_t              w_head;
  logic [2*LANES-1:0] w_unp_w, w_unp_i;
  logic [BYTES-1:0]   w_inv_w, w_inv_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] i_ptr);
    return (i_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : i_ptr + PTR_W'(1);
  endfunction

  for (genvar b = 0; b < BYTES; b++) begin : g_unpack
    pt5_unpacker u_unp_w (
      .i_byte    (i_mem_w_rdata[8*b +: 8]),
      .o_trits   (w_unp_w[10*b +: 10]),
      .o_invalid (w_inv_w[b])
    );
    pt5_unpacker u_unp_i (
      .i_byte    (i_mem_i_rdata[8*b +: 8]),
      .o_trits   (w_unp_i[10*b +: 10]),
      .o_invalid (w_inv_i[b])
    );
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = (r_count != '0) && out_if.out_ready;
  assign w_last_hs   = w_pop && w_head.last;
  // Credit counts buffered beats plus both read pipeline stages; pops in the
  // same cycle are deliberately not credited back early.
  assign w_credit_ok = (int'(r_count) + int'(r_rd) + int'(r_inflight)) < FIFO_DEPTH;

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_issue      = 1'b0;
    w_last_issue = (r_issue_cnt == r_depth - DEPTH_WIDTH'(1));
    w_done_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_start_ok = i_start;
        if (i_start) begin
          if (i_cfg_depth == '0)
            w_done_set = 1'b1;
          else if (i_cfg_depth == DEPTH_WIDTH'(1))
            w_state_next = ST_DRAIN;
          else
            w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_issue = w_credit_ok;
        if (w_credit_ok && w_last_issue)
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_last_hs) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address generation, read strobes and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth         <= '0;
      r_issue_cnt     <= '0;
      r_stride        <= '0;
      r_bcast         <= 1'b0;
      r_addr_w        <= '0;
      r_addr_i        <= '0;
      r_rd            <= 1'b0;
      r_rd_last       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_done          <= w_done_set;
      r_inflight      <= r_rd;
      r_inflight_last <= r_rd_last;
      r_rd            <= 1'b0;
      r_rd_last       <= 1'b0;
      if (w_start_ok) begin
        r_err    <= 1'b0;
        r_depth  <= i_cfg_depth;
        r_stride <= i_cfg_stride;
        r_bcast  <= i_cfg_bcast_i;
        if (i_cfg_depth != '0) begin
          // Beat 0 is issued straight from the start edge.
          r_addr_w    <= i_cfg_base_w;
          r_addr_i    <= i_cfg_base_i;
          r_rd        <= 1'b1;
          r_rd_last   <= (i_cfg_depth == DEPTH_WIDTH'(1));
          r_issue_cnt <= DEPTH_WIDTH'(1);
        end
      end else if (w_issue) begin
        r_addr_w    <= r_addr_w + ADDR_WIDTH'(r_stride);
        r_addr_i    <= r_bcast ? r_addr_i : r_addr_i + ADDR_WIDTH'(r_stride);
        r_rd        <= 1'b1;
        r_rd_last   <= w_last_issue;
        r_issue_cnt <= r_issue_cnt + DEPTH_WIDTH'(1);
      end
      if (r_inflight && (|{w_inv_w, w_inv_i}))
        r_err <= 1'b1;
    end
  end

  // Output buffer: unpacked beats are written as read data arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffer storage is reset because out_* read it directly and
      // must show zeros after reset; it is only FIFO_DEPTH entries.
      for (int e = 0; e < FIFO_DEPTH; e++) r_fifo[e] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= '{w_trits: w_unp_w, i_trits: w_unp_i, last: r_inflight_last};
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_err_invalid = r_err;
  assign o_mem_w_rd    = r_rd;
  assign o_mem_i_rd    = r_rd;
  assign o_mem_w_addr  = r_addr_w;
  assign o_mem_i_addr  = r_addr_i;

  assign out_if.out_valid   = (r_count != '0);
  assign out_if.out_w_trits = w_head.w_trits;
  assign out_if.out_i_trits = w_head.i_trits;
  assign out_if.out_last    = w_head.last;

endmodule
